// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: mem_signals bit positions,
// FSM state and access-size encodings, byte-enable constants.
package mem_pkg;

    localparam int SIG_SIGN  = 5;
    localparam int SIG_READ  = 4;
    localparam int SIG_WRITE = 3;
    localparam int SIG_WORD  = 2;
    localparam int SIG_HALF  = 1;
    localparam int SIG_BYTE  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Word beats half beats byte; an empty size field is treated as a word.
    function automatic size_t decode_size(input logic [5:0] sig);
        if (sig[SIG_WORD]) return SZ_WORD;
        if (sig[SIG_HALF]) return SZ_HALF;
        if (sig[SIG_BYTE]) return SZ_BYTE;
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: store replication and byte enables on the way out,
// lane select plus sign/zero extension on the way back.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [1:0]         i_st_size,
    input  logic [1:0]         i_st_addr_lo,
    input  logic [NB_DATA-1:0] i_st_data,
    output logic [3:0]         o_be,
    output logic [NB_DATA-1:0] o_wdata,
    input  logic [1:0]         i_ld_size,
    input  logic               i_ld_sign,
    input  logic [1:0]         i_ld_addr_lo,
    input  logic [NB_DATA-1:0] i_rdata,
    output logic [NB_DATA-1:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_st_data;
        case (i_st_size)
            SZ_BYTE: begin
                o_be    = BE_BYTE0 << i_st_addr_lo;
                o_wdata = {(NB_DATA/8){i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_be    = i_st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                o_wdata = {(NB_DATA/16){i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ld_byte = i_rdata[{i_ld_addr_lo, 3'b000} +: 8];
        w_ld_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ld_data = i_rdata;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{(NB_DATA-8){i_ld_sign & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_data = {{(NB_DATA-16){i_ld_sign & w_ld_half[15]}}, w_ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: IDLE -> ACCESS -> RESP over a req/ack data memory.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 32,
    parameter int NB_MEM_SIGNALS = 6
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      valid_i,
    input  logic [NB_MEM_SIGNALS-1:0] mem_signals_i,
    input  logic [NB_ADDR-1:0]        addr_i,
    input  logic [NB_DATA-1:0]        store_data_i,
    output logic                      stall_o,
    output logic [NB_DATA-1:0]        load_data_o,
    output logic                      load_valid_o,
    output logic                      misalign_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [NB_ADDR-1:0]        mem_addr_o,
    output logic [NB_DATA-1:0]        mem_wdata_o,
    output logic [3:0]                mem_be_o,
    input  logic                      mem_ack_i,
    input  logic [NB_DATA-1:0]        mem_rdata_i
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_sign;
    logic                r_read;
    logic                r_misalign;
    size_t               r_size;
    logic [1:0]          r_addr_lo;
    logic [NB_ADDR-1:0]  r_addr;
    logic [NB_DATA-1:0]  r_wdata;
    logic [3:0]          r_be;
    logic [NB_DATA-1:0]  r_load_data;

    logic                w_start;
    logic                w_misalign;
    logic                w_stall;
    size_t               w_size;
    logic [3:0]          w_be;
    logic [NB_DATA-1:0]  w_wdata;
    logic [NB_DATA-1:0]  w_ld_data;

    assign w_start = valid_i & (mem_signals_i[SIG_READ] ^ mem_signals_i[SIG_WRITE]);
    assign w_size  = decode_size(mem_signals_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((w_size == SZ_HALF) && addr_i[0]) ||
                        ((w_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    mem_lane_align #(.NB_DATA(NB_DATA)) u_lane_align (
        .i_st_size    (w_size),
        .i_st_addr_lo (addr_i[1:0]),
        .i_st_data    (store_data_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .i_ld_size    (r_size),
        .i_ld_sign    (r_sign),
        .i_ld_addr_lo (r_addr_lo),
        .i_rdata      (mem_rdata_i),
        .o_ld_data    (w_ld_data)
    );

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_stall      = 1'b1;
                    w_next_state = w_misalign ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_stall = 1'b1;
                if (mem_ack_i) w_next_state = ST_RESP;
            end
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Handshake: mem_req_o rises in the first ACCESS cycle and stays high with
    // unchanged we/addr/wdata/be until the edge on which mem_ack_i is sampled high.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_sign      <= 1'b0;
            r_read      <= 1'b0;
            r_misalign  <= 1'b0;
            r_size      <= SZ_WORD;
            r_addr_lo   <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= 4'b0000;
            r_load_data <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && w_start) begin
                r_sign     <= mem_signals_i[SIG_SIGN];
                r_read     <= mem_signals_i[SIG_READ];
                r_misalign <= w_misalign;
                r_size     <= w_size;
                r_addr_lo  <= addr_i[1:0];
                r_addr     <= {addr_i[NB_ADDR-1:2], 2'b00};
                r_wdata    <= w_wdata;
                r_be       <= w_be;
            end
            if ((r_state == ST_ACCESS) && mem_ack_i && r_read) begin
                r_load_data <= w_ld_data;
            end
        end
    end

    assign stall_o      = w_stall;
    assign load_data_o  = r_load_data;
    assign load_valid_o = (r_state == ST_RESP) && r_read && !r_misalign;
    assign mem_req_o    = (r_state == ST_ACCESS);
    assign mem_we_o     = (r_state == ST_ACCESS) && !r_read;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign mem_be_o     = r_be;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_o = (r_state == ST_RESP) && r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller that consumes the decoded `mem_signals` bundle (sign, read, write, word/half/byte) produced by the control unit, and executes the load or store against a word-wide, byte-enabled data memory using a req/ack handshake. It sits in the MEM stage between the EX/MEM pipeline register and the data memory. It stalls the pipeline while an access is outstanding and returns sign- or zero-extended load data to the MEM/WB register.

## Interface
- `NB_DATA`, 32, data and memory word width.
- `NB_ADDR`, 32, address width.
- `NB_MEM_SIGNALS`, 6, width of the memory control bundle.

Ports:
- `clock_i` in 1: single clock; all state on rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `valid_i` in 1: EX/MEM holds a live instruction.
- `mem_signals_i` in 6: [5] sign, [4] read, [3] write, [2] word, [1] half, [0] byte.
- `addr_i` in NB_ADDR: effective address (ALU result).
- `store_data_i` in NB_DATA: rt value for stores.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `load_data_o` out NB_DATA: extended load result, held until the next load completes.
- `load_valid_o` out 1: one-cycle pulse when `load_data_o` updates.
- `misalign_o` out 1: one-cycle pulse on a misaligned access.
- `mem_req_o` out 1, `mem_we_o` out 1, `mem_addr_o` out NB_ADDR (bits [1:0] = 0), `mem_wdata_o` out NB_DATA, `mem_be_o` out 4: memory request channel.
- `mem_ack_i` in 1, `mem_rdata_i` in NB_DATA: memory response.

## Operation
- FSM with three states: IDLE, ACCESS, RESP.
- Start condition is `valid_i & (read ^ write)`. `read & write` or neither means no access, and the unit stays in IDLE.
- IDLE: on start, latch sign, read/write, size, address, and lane-aligned store data, then go to ACCESS.
- ACCESS: hold `mem_req_o=1` with stable request fields until `mem_ack_i`. On ack, a load registers the extended data into `load_data_o`. Then go to RESP.
- RESP: `load_valid_o=1` for loads only. Go to IDLE. The instruction still present on the inputs in this cycle is ignored.
- Size priority is word > half > byte. Size 000 with read or write is treated as word.
- Lanes are little-endian. k = addr[1:0].
  - Byte: `mem_be_o = 1<<k`, `mem_wdata_o = {4{data[7:0]}}`.
  - Half: `mem_be_o` = 0011 if addr[1]=0, else 1100. `mem_wdata_o = {2{data[15:0]}}`.
  - Word: `mem_be_o = 1111`.
- Loads select the byte or halfword from the lane given by address.
  - sign=1: sign-extend to NB_DATA.
  - sign=0: zero-extend.
  - Words pass through unchanged.
- `mem_ack_i` is ignored outside ACCESS.

## Timing
- `stall_o = (IDLE & start) | ACCESS`. It is combinational, so the pipeline freezes in the accept cycle.
- Zero-wait memory (ack in the first ACCESS cycle):
  - Cycle 0: accept, stall=1.
  - Cycle 1: ACCESS, req=1, ack, stall=1.
  - Cycle 2: RESP, load_valid=1, stall=0.
- Each wait state adds one ACCESS cycle.
- Back-to-back accesses: a new start is evaluated only in IDLE, so there is at least one non-stalled cycle (RESP) between accesses.
- Reset values: state IDLE; `load_data_o=0`; all other outputs 0.
- Reset asserted during ACCESS drops `mem_req_o` the following cycle and abandons the request. The memory must tolerate an abandoned request.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - Misaligned accesses are detected: half with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned access skips ACCESS (no `mem_req_o`) and goes IDLE→RESP.
  - `misalign_o` pulses in RESP; `load_valid_o` stays 0 and `load_data_o` is unchanged.
- Not defined:
  - `misalign_o` is tied 0.
  - Word accesses ignore addr[1:0]; half accesses use addr[1] only.

## Structure
- Shared package/header `mem_pkg`:
  - `mem_signals` bit indices (SIGN=5, READ=4, WRITE=3, WORD=2, HALF=1, BYTE=0).
  - FSM state encodings.
  - Byte-enable constants.
- One combinational sub-module, `mem_lane_align`, handles store replication and byte-enable generation plus load lane select and extension. The top level holds the FSM and registers.

## Test plan
- LB, sign=1, addr=0x1003, rdata=0x80FF_FF7F, zero-wait → `mem_be_o=1000`, `load_data_o=0xFFFF_FF80`, `load_valid_o` at cycle 2.
- LBU-style (sign=0) byte at addr=0x1003 with the same rdata → `load_data_o=0x0000_0080`.
- SH, addr=0x2002, store_data=0x1234_ABCD → `mem_we_o=1`, `mem_be_o=1100`, `mem_wdata_o=0xABCD_ABCD`, `load_valid_o` stays 0.
- LW, addr=0x40, ack delayed 3 cycles → `stall_o` high 4 cycles, `mem_req_o` and `mem_addr_o=0x40` stable throughout, one `load_valid_o` pulse.
- LW addr=0x42 with `MEM_ALIGN_CHECK_EN` → no `mem_req_o`, `misalign_o` pulse, `load_data_o` unchanged. Without the macro → access at 0x40.
- Reset pulse during a 5-cycle-wait ACCESS → `mem_req_o=0` and `stall_o=0` next cycle, no `load_valid_o`, and a following SW completes normally.
